irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter MEI_SYNC_STAGES, default 2, meaning the synchroniser depth (in flops) for the external interrupt input.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-003 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port msip_in (IRQ3 from the timer/soft-interrupt unit), input, 1 bit: software interrupt level.
REQ-005 The block SHALL have port mtip_in (IRQ7 from the timer/soft-interrupt unit), input, 1 bit: timer interrupt level.
REQ-006 The block SHALL have port meip_in, input, 1 bit: external interrupt level, asynchronous to clk.
REQ-007 The block SHALL have ports csr_we (input, 1), csr_addr (input, 12), csr_wdata (input, 32) and csr_rdata (output, 32): the core CSR access port.
REQ-008 The block SHALL have port trap_req, output, 1 bit: interrupt trap request to the core.
REQ-009 The block SHALL have port trap_cause, output, 4 bits: the interrupt code (3, 7 or 11).
REQ-010 The block SHALL have port trap_ack, input, 1 bit: the core takes the trap this cycle.
REQ-011 The block SHALL have port mret, input, 1 bit: the core retires an MRET this cycle.

Function
REQ-012 The block SHALL use msip_in and mtip_in as already synchronous and pass meip_in through a MEI_SYNC_STAGES-flop synchroniser before use.
REQ-013 mip (0x344) SHALL read {20'b0, meip_s, 3'b0, mtip_in, 3'b0, msip_in, 3'b0} and writes to it SHALL be ignored.
REQ-014 mie (0x304) SHALL implement only bits 11, 7 and 3 as read/write; all other bits SHALL read 0.
REQ-015 mstatus (0x300) SHALL implement only MIE (bit 3) and MPIE (bit 7); all other bits SHALL read 0 and ignore writes.
REQ-016 csr_rdata SHALL be combinational from csr_addr, and SHALL be 0 for any address other than 0x300, 0x304 or 0x344.
REQ-017 A CSR write SHALL take effect on the clk edge on which csr_we=1.
REQ-018 The block SHALL define pend = mip & mie, and SHALL define fire = MIE && |pend.
REQ-019 Priority SHALL be fixed: 11 > 3 > 7.
REQ-020 The block SHALL have an FSM with states IDLE and REQ.
REQ-021 IDLE->REQ: when fire=1, the block SHALL latch the highest-priority pending code into trap_cause and register trap_req=1 on the next edge (1-cycle latency).
REQ-022 In REQ, trap_req SHALL stay 1 and trap_cause SHALL stay stable, including when a higher-priority source arrives.
REQ-023 REQ->IDLE on trap_ack=1: on that edge, MPIE<=MIE, MIE<=0, and trap_req<=0.
REQ-024 REQ->IDLE without ack: if fire=0 (source dropped, mie bit cleared or MIE cleared), trap_req<=0 on the next edge and trap_cause SHALL be held.
REQ-025 On mret=1: MIE<=MPIE and MPIE<=1.
REQ-026 Simultaneous events, trap_ack vs csr_we to mstatus: trap_ack SHALL win for MIE/MPIE.
REQ-027 Simultaneous events, trap_ack vs mret: trap_ack SHALL win.
REQ-028 Simultaneous events, mret vs csr_we to mstatus: mret SHALL win.
REQ-029 trap_ack while in IDLE SHALL be ignored.
REQ-030 The block SHALL not re-request in the cycle after ack, because MIE=0.

Reset
REQ-031 While resetn=0: trap_req=0, trap_cause=0, MIE=0, MPIE=0, mie=0, FSM=IDLE, and synchroniser flops cleared.
REQ-032 Reset asserted mid-REQ SHALL drop trap_req on that edge, with no ack required.
REQ-033 csr_rdata SHALL reflect the reset register values combinationally.

Structure
REQ-034 A shared package SHALL hold the CSR address constants (0x300, 0x304, 0x344), the bit indices (3, 7, 11), the cause codes, and the FSM state enum.
REQ-035 The synchroniser SHALL be one sub-module, sync_ff (parameter STAGES, 1-bit data), instantiated for meip_in.

Verification
REQ-036 Timer interrupt: write mie=0x80 and mstatus=0x8, then raise mtip_in -> trap_req=1 one cycle later with trap_cause=7; after trap_ack, trap_req=0, mstatus reads 0x80.
REQ-037 Priority: raise msip_in, mtip_in and meip_in together with mie=0x888 and MIE=1 -> trap_cause=11; hold ack for 5 cycles -> cause stays 11.
REQ-038 Withdrawal: enter REQ on cause 3, then drop msip_in before ack -> trap_req=0 next cycle, FSM=IDLE, trap_cause still 3.
REQ-039 MRET: after ack (mstatus=0x80), pulse mret -> mstatus reads 0x88; with mtip_in still high, trap_req re-asserts one cycle later.
REQ-040 Collision/reset: assert trap_ack and mret in the same cycle -> mstatus=0x80; assert resetn=0 in REQ -> trap_req=0 next edge and all CSRs read 0.
REQ-041 External sync latency: meip_in pulse with MEI_SYNC_STAGES=2 -> mip bit 11 visible exactly 2 edges later, and trap_req follows 1 edge after that.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller.
// Latency: n/a (constants, types and a pure priority function).
// Backpressure: n/a.
// Contents: CSR addresses, mip/mie/mstatus bit indices, cause codes,
// FSM state enum, pending-vector struct and the fixed-priority encoder.
package irq_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Interrupt bit positions within mip/mie.
  localparam int BIT_MSI = 3;
  localparam int BIT_MTI = 7;
  localparam int BIT_MEI = 11;

  // Bit positions within mstatus.
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Compact view of the three implemented interrupt lines.
  typedef struct packed {
    logic mei;
    logic mti;
    logic msi;
  } irq_vec_t;

  // Fixed priority: external > software > timer.
  function automatic logic [3:0] prio_cause(input irq_vec_t pend);
    logic [3:0] cause;
    cause = 4'd0;
    if (pend.mei)      cause = CAUSE_MEI;
    else if (pend.msi) cause = CAUSE_MSI;
    else if (pend.mti) cause = CAUSE_MTI;
    return cause;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level.
// Latency: STAGES clk edges from d_i to q_o.
// Backpressure: none; free-running shift chain.
// Ports: clk, resetn (sync, active-low), d_i (async level), q_o (synchronised).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mip/mie/mstatus CSRs plus trap request FSM.
// Latency: trap_req registers 1 edge after fire; meip_in adds MEI_SYNC_STAGES edges.
// Backpressure: trap_req/trap_cause held until trap_ack or until the source withdraws.
// Ports: clk/resetn; msip_in, mtip_in (sync), meip_in (async); CSR port
// csr_we/csr_addr/csr_wdata/csr_rdata; trap_req/trap_cause/trap_ack; mret.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int MEI_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        msip_in,
  input  logic        mtip_in,
  input  logic        meip_in,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        trap_req,
  output logic [3:0]  trap_cause,
  input  logic        trap_ack,
  input  logic        mret
);

  logic     meip_s;
  irq_vec_t mip_vec;
  irq_vec_t pend;
  logic     fire;

  irq_vec_t mie_q, mie_d;
  logic     mst_mie_q, mst_mie_d;
  logic     mst_mpie_q, mst_mpie_d;
  state_e   state_q, state_d;
  logic [3:0] cause_q, cause_d;

  logic mstatus_wr;
  logic mie_wr;
  logic ack_take;

  // Only bits 3, 7 and 11 of write data are ever consumed.
  logic unused_wdata;
  assign unused_wdata = ^{csr_wdata[31:12], csr_wdata[10:8],
                          csr_wdata[6:4], csr_wdata[2:0]};

  sync_ff #(
    .STAGES (MEI_SYNC_STAGES)
  ) u_meip_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (meip_in),
    .q_o    (meip_s)
  );

  assign mip_vec = '{mei: meip_s, mti: mtip_in, msi: msip_in};
  assign pend    = mip_vec & mie_q;
  assign fire    = mst_mie_q && (|pend);

  assign mstatus_wr = csr_we && (csr_addr == CSR_MSTATUS);
  assign mie_wr     = csr_we && (csr_addr == CSR_MIE);
  // An ack only means something while a request is outstanding.
  assign ack_take   = (state_q == ST_REQ) && trap_ack;

  // mstatus update priority: trap entry, then mret, then software write.
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    if (ack_take) begin
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (mstatus_wr) begin
      mst_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
      mst_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
    end
  end

  always_comb begin
    mie_d = mie_q;
    if (mie_wr) begin
      mie_d = '{mei: csr_wdata[BIT_MEI],
                mti: csr_wdata[BIT_MTI],
                msi: csr_wdata[BIT_MSI]};
    end
  end

  // Cause is captured only on IDLE->REQ, so it stays stable through REQ
  // and is still readable after a withdrawal.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d = ST_REQ;
          cause_d = prio_cause(pend);
        end
      end
      ST_REQ: begin
        if (trap_ack || !fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cause_q    <= 4'd0;
      mie_q      <= '0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      mie_q      <= mie_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mst_mie_q;
        csr_rdata[MSTATUS_MPIE_BIT] = mst_mpie_q;
      end
      CSR_MIE: begin
        csr_rdata[BIT_MEI] = mie_q.mei;
        csr_rdata[BIT_MTI] = mie_q.mti;
        csr_rdata[BIT_MSI] = mie_q.msi;
      end
      CSR_MIP: begin
        csr_rdata[BIT_MEI] = mip_vec.mei;
        csr_rdata[BIT_MTI] = mip_vec.mti;
        csr_rdata[BIT_MSI] = mip_vec.msi;
      end
      default: csr_rdata = 32'd0;
    endcase
  end

  assign trap_req   = (state_q == ST_REQ);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic        clk;
  logic        resetn;
  logic        msip_in;
  logic        mtip_in;
  logic        meip_in;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        trap_req;
  logic [3:0]  trap_cause;
  logic        trap_ack;
  logic        mret;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.MEI_SYNC_STAGES(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .msip_in    (msip_in),
    .mtip_in    (mtip_in),
    .meip_in    (meip_in),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .trap_req   (trap_req),
    .trap_cause (trap_cause),
    .trap_ack   (trap_ack),
    .mret       (mret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; msip_in = 0; mtip_in = 0; meip_in = 0;
    csr_we = 0; csr_addr = 12'h0; csr_wdata = 32'h0; trap_ack = 0; mret = 0;
    tick(); tick();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", trap_req); end
    checks++; if (trap_cause !== 4'd0) begin errors++; $display("FAIL rst_cause: got %0d want 0", trap_cause); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_mstatus: got %h want 0", csr_rdata); end
    csr_addr = 12'h304; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_mie: got %h want 0", csr_rdata); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_csr_access();
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_addr = 12'h304; #1;
    checks++; if (csr_rdata !== 32'h888) begin errors++; $display("FAIL csr_mie_mask: got %h want 888", csr_rdata); end
    csr_write(12'h300, 32'hFFFF_FFFF);
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL csr_mstatus_mask: got %h want 88", csr_rdata); end
    csr_write(12'h300, 32'h0);
    csr_write(12'h304, 32'h0);
    csr_write(12'h344, 32'hFFFF_FFFF);
    msip_in = 1'b1;
    csr_addr = 12'h344; #1;
    checks++; if (csr_rdata !== 32'h8) begin errors++; $display("FAIL csr_mip_ro: got %h want 8", csr_rdata); end
    csr_addr = 12'h305; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL csr_unmapped: got %h want 0", csr_rdata); end
    msip_in = 1'b0;
    tick();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL csr_no_fire: got %0b want 0", trap_req); end
  endtask

  task automatic test_timer_and_mret();
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    mtip_in = 1'b1; #1;
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL tmr_pre: got %0b want 0", trap_req); end
    tick();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL tmr_req: got %0b want 1", trap_req); end
    checks++; if (trap_cause !== 4'd7) begin errors++; $display("FAIL tmr_cause: got %0d want 7", trap_cause); end
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL tmr_ack_req: got %0b want 0", trap_req); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL tmr_ack_mstatus: got %h want 80", csr_rdata); end
    tick();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL tmr_no_rereq: got %0b want 0", trap_req); end
    mret = 1'b1; tick(); mret = 1'b0;
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL mret_mstatus: got %h want 88", csr_rdata); end
    tick();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL mret_rereq: got %0b want 1", trap_req); end
  endtask

  task automatic test_collisions();
    // In REQ with mstatus=0x88: ack beats mret.
    trap_ack = 1'b1; mret = 1'b1; tick(); trap_ack = 1'b0; mret = 1'b0;
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL col_ack_mret: got %h want 80", csr_rdata); end
    mret = 1'b1; tick(); mret = 1'b0;
    tick();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL col_rereq: got %0b want 1", trap_req); end
    // Ack beats a simultaneous mstatus write.
    trap_ack = 1'b1; csr_write(12'h300, 32'h0); trap_ack = 1'b0;
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL col_ack_wr: got %h want 80", csr_rdata); end
    // mret beats a simultaneous mstatus write.
    mret = 1'b1; csr_write(12'h300, 32'h0); mret = 1'b0;
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL col_mret_wr: got %h want 88", csr_rdata); end
    tick();
    mtip_in = 1'b0;
    csr_write(12'h300, 32'h8);
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL col_drop_req: got %0b want 0", trap_req); end
    // Ack with nothing outstanding must not touch mstatus.
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h08) begin errors++; $display("FAIL idle_ack: got %h want 08", csr_rdata); end
    csr_write(12'h300, 32'h0);
  endtask

  task automatic test_priority();
    csr_write(12'h304, 32'h888);
    msip_in = 1'b1; mtip_in = 1'b1; meip_in = 1'b1;
    tick(); tick(); tick();
    csr_addr = 12'h344; #1;
    checks++; if (csr_rdata !== 32'h888) begin errors++; $display("FAIL prio_mip: got %h want 888", csr_rdata); end
    csr_write(12'h300, 32'h8);
    tick();
    checks++; if (trap_cause !== 4'd11) begin errors++; $display("FAIL prio_cause: got %0d want 11", trap_cause); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (trap_req !== 1'b1 || trap_cause !== 4'd11) begin errors++; $display("FAIL prio_hold%0d: got req=%0b cause=%0d want 1/11", i, trap_req, trap_cause); end
    end
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    msip_in = 0; mtip_in = 0; meip_in = 0;
    tick(); tick(); tick();
    // A higher-priority arrival must not disturb an outstanding request.
    csr_write(12'h300, 32'h8);
    mtip_in = 1'b1; tick();
    msip_in = 1'b1; meip_in = 1'b1;
    tick(); tick(); tick();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 4'd7) begin errors++; $display("FAIL prio_stable: got req=%0b cause=%0d want 1/7", trap_req, trap_cause); end
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    msip_in = 0; mtip_in = 0; meip_in = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_withdraw();
    csr_write(12'h300, 32'h8);
    msip_in = 1'b1; tick();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 4'd3) begin errors++; $display("FAIL wd_enter: got req=%0b cause=%0d want 1/3", trap_req, trap_cause); end
    msip_in = 1'b0; tick();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL wd_req: got %0b want 0", trap_req); end
    checks++; if (trap_cause !== 4'd3) begin errors++; $display("FAIL wd_cause: got %0d want 3", trap_cause); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h08) begin errors++; $display("FAIL wd_mstatus: got %h want 08", csr_rdata); end
    tick();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL wd_idle: got %0b want 0", trap_req); end
    csr_write(12'h300, 32'h0);
  endtask

  task automatic test_meip_sync_and_reset();
    csr_write(12'h304, 32'h800);
    csr_write(12'h300, 32'h8);
    csr_addr = 12'h344;
    meip_in = 1'b1;
    tick();
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL sync_e1: got %h want 0", csr_rdata); end
    tick();
    checks++; if (csr_rdata !== 32'h800) begin errors++; $display("FAIL sync_e2: got %h want 800", csr_rdata); end
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL sync_e2_req: got %0b want 0", trap_req); end
    tick();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 4'd11) begin errors++; $display("FAIL sync_e3: got req=%0b cause=%0d want 1/11", trap_req, trap_cause); end
    // Reset while requesting: no ack needed, everything clears.
    resetn = 1'b0; meip_in = 1'b0;
    tick();
    checks++; if (trap_req !== 1'b0 || trap_cause !== 4'd0) begin errors++; $display("FAIL rstreq: got req=%0b cause=%0d want 0/0", trap_req, trap_cause); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rstreq_mstatus: got %h want 0", csr_rdata); end
    csr_addr = 12'h304; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rstreq_mie: got %h want 0", csr_rdata); end
    csr_addr = 12'h344; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rstreq_mip: got %h want 0", csr_rdata); end
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_csr_access();
    test_timer_and_mret();
    test_collisions();
    test_priority();
    test_withdraw();
    test_meip_sync_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
